// File: rtl/i2c_condition_generator.sv
// Master-side I2C sequencer: START, STOP, byte WRITE and byte READ on open-drain
// SCL/SDA from a single-command valid/ready interface, with clock-stretch support.
module i2c_condition_generator #(
  parameter int QTR_CYCLES = 250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid_in,
  output logic       cmd_ready_out,
  input  logic [1:0] cmd_in,
  input  logic [7:0] data_in,
  input  logic       ack_in,
  output logic [7:0] data_out,
  output logic       ack_out,
  output logic       done_out,
  output logic       busy_out,
  output logic       scl_out,
  output logic       sda_out,
  input  logic       scl_in,
  input  logic       sda_in
);

  localparam int CW = (QTR_CYCLES > 1) ? $clog2(QTR_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(QTR_CYCLES - 1);

  localparam logic [1:0] CMD_START = 2'd0;
  localparam logic [1:0] CMD_STOP  = 2'd1;
  localparam logic [1:0] CMD_WRITE = 2'd2;
  localparam logic [1:0] CMD_READ  = 2'd3;

  typedef enum logic [2:0] {S_IDLE, S_START, S_STOP, S_BIT, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [1:0]    phase_q, phase_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    idx_q, idx_d;
  logic [1:0]    cmd_q, cmd_d;
  logic          ack_q, ack_d;
  logic [7:0]    sh_q, sh_d;
  logic          samp_q, samp_d;
  logic [7:0]    data_out_q, data_out_d;
  logic          ack_out_q, ack_out_d;
  logic          scl_q, scl_d;
  logic          sda_q, sda_d;

  logic idle_like;
  logic stall;

  assign idle_like     = (state_q == S_IDLE) || (state_q == S_DONE);
  // A released SCL held low by the target freezes the quarter timer.
  assign stall         = scl_q && !scl_in;
  assign cmd_ready_out = idle_like;
  assign busy_out      = !idle_like;
  assign done_out      = (state_q == S_DONE);
  assign data_out      = data_out_q;
  assign ack_out       = ack_out_q;
  assign scl_out       = scl_q;
  assign sda_out       = sda_q;

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    cmd_d      = cmd_q;
    ack_d      = ack_q;
    sh_d       = sh_q;
    samp_d     = samp_q;
    data_out_d = data_out_q;
    ack_out_d  = ack_out_q;
    scl_d      = scl_q;
    sda_d      = sda_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (cmd_valid_in) begin
          cmd_d   = cmd_in;
          ack_d   = ack_in;
          sh_d    = data_in;
          phase_d = 2'd0;
          cnt_d   = CNT_LOAD;
          idx_d   = 4'd0;
          case (cmd_in)
            CMD_START: state_d = S_START;
            CMD_STOP:  state_d = S_STOP;
            default:   state_d = S_BIT;
          endcase
        end
      end
      default: begin
        if (!stall) begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
          end else begin
            cnt_d   = CNT_LOAD;
            phase_d = phase_q + 2'd1;
            if (state_q == S_BIT && phase_q == 2'd2) samp_d = sda_in;
            if (phase_q == 2'd3) begin
              if (state_q != S_BIT) begin
                state_d = S_DONE;
              end else if (idx_q == 4'd8) begin
                state_d = S_DONE;
                if (cmd_q == CMD_READ) data_out_d = sh_q;
                else                   ack_out_d  = samp_q;
              end else begin
                idx_d = idx_q + 4'd1;
                sh_d  = {sh_q[6:0], samp_q};
              end
            end
          end
        end
      end
    endcase

    // Lines are registered from the next state so they change glitch-free.
    case (state_d)
      S_START: begin
        case (phase_d)
          2'd0:    sda_d = 1'b1;
          2'd1:    begin scl_d = 1'b1; sda_d = 1'b1; end
          2'd2:    begin scl_d = 1'b1; sda_d = 1'b0; end
          default: begin scl_d = 1'b0; sda_d = 1'b0; end
        endcase
      end
      S_STOP: begin
        scl_d = (phase_d != 2'd0);
        sda_d = phase_d[1];
      end
      S_BIT: begin
        scl_d = (phase_d == 2'd1) || (phase_d == 2'd2);
        if (idx_d == 4'd8) sda_d = (cmd_d == CMD_WRITE) ? 1'b1 : ack_d;
        else               sda_d = (cmd_d == CMD_WRITE) ? sh_d[7] : 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      phase_q    <= 2'd0;
      cnt_q      <= '0;
      idx_q      <= 4'd0;
      cmd_q      <= 2'd0;
      ack_q      <= 1'b0;
      sh_q       <= 8'h00;
      samp_q     <= 1'b0;
      data_out_q <= 8'h00;
      ack_out_q  <= 1'b0;
      scl_q      <= 1'b1;
      sda_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      cmd_q      <= cmd_d;
      ack_q      <= ack_d;
      sh_q       <= sh_d;
      samp_q     <= samp_d;
      data_out_q <= data_out_d;
      ack_out_q  <= ack_out_d;
      scl_q      <= scl_d;
      sda_q      <= sda_d;
    end
  end

endmodule

// File: tb/tb_i2c_condition_generator.sv
// Scoreboard bench for i2c_condition_generator: open-drain bus model with a
// simple target, a response monitor and a bus-symbol monitor.
module tb_i2c_condition_generator;
  localparam int Q = 4;

  logic       clk;
  logic       rst;
  logic       cmd_valid_in;
  logic [1:0] cmd_in;
  logic [7:0] data_in;
  logic       ack_in;
  logic       cmd_ready_out;
  logic [7:0] data_out;
  logic       ack_out;
  logic       done_out;
  logic       busy_out;
  logic       scl_out;
  logic       sda_out;
  logic       scl_in;
  logic       sda_in;

  int   stretch_left = 0;
  logic tb_sda = 1'b1;

  assign scl_in = scl_out & (stretch_left == 0);
  assign sda_in = sda_out & tb_sda;

  i2c_condition_generator #(.QTR_CYCLES(Q)) dut (
    .clk(clk), .rst(rst), .cmd_valid_in(cmd_valid_in), .cmd_ready_out(cmd_ready_out),
    .cmd_in(cmd_in), .data_in(data_in), .ack_in(ack_in), .data_out(data_out),
    .ack_out(ack_out), .done_out(done_out), .busy_out(busy_out), .scl_out(scl_out),
    .sda_out(sda_out), .scl_in(scl_in), .sda_in(sda_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  function automatic void chk(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  typedef struct {int lat; int data; int ack;} resp_t;
  typedef struct {bit rd; logic [7:0] bval; bit ack;} tgt_t;

  resp_t resp_q[$];
  int    sym_q[$];
  tgt_t  tgt_q[$];

  // Response monitor: pops one expectation per done pulse.
  resp_t e_r;
  int    acc_cyc = 0;
  int    n_acc = 0;
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (done_out) begin
        if (resp_q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          e_r = resp_q.pop_front();
          chk("latency", cyc - acc_cyc, e_r.lat);
          chk("data_out", int'(data_out), e_r.data);
          chk("ack_out", int'(ack_out), e_r.ack);
        end
      end
      if (cmd_valid_in && cmd_ready_out) begin
        acc_cyc = cyc;
        n_acc++;
      end
    end
  end

  // Bus model: target behaviour plus decoding of bits/START/STOP on the lines.
  bit   mon_en = 0;
  int   stretch_at = 0;
  int   byte_cnt = 0;
  bit   byte_act = 0;
  int   tb_bit = 0;
  tgt_t cur;
  logic prev_scl = 1'b1, prev_sda = 1'b1, scl_l, sda_l;
  bit   hi_chg = 0;
  logic hi_val = 1'b1;
  int   hi_cnt = 0;

  task automatic sym_chk(int s);
    if (mon_en) begin
      if (sym_q.size() == 0) chk("unexpected_bus_symbol", s, -1);
      else chk("bus_symbol", s, sym_q.pop_front());
    end
  endtask

  task automatic tgt_drive();
    if (tb_bit >= 9) begin
      tb_sda   = 1'b1;
      byte_act = 0;
    end else if (cur.rd) tb_sda = (tb_bit < 8) ? cur.bval[7 - tb_bit] : 1'b1;
    else tb_sda = (tb_bit == 8) ? cur.ack : 1'b1;
  endtask

  always @(negedge clk) begin
    if (rst !== 1'b0) begin
      stretch_left = 0;
      tb_sda       = 1'b1;
      byte_act     = 0;
      prev_scl     = 1'b1;
      prev_sda     = 1'b1;
    end else begin
      if (scl_out && stretch_left > 0) stretch_left--;
      scl_l = scl_out & (stretch_left == 0);
      sda_l = sda_out & tb_sda;
      if (scl_l && prev_scl && sda_l != prev_sda) begin
        hi_chg = 1;
        sym_chk(sda_l ? 3 : 2);
      end
      if (scl_l && !prev_scl) begin
        hi_cnt = 1;
        hi_chg = 0;
        hi_val = sda_l;
      end else if (scl_l) hi_cnt++;
      if (!scl_l && prev_scl) begin
        if (!hi_chg && mon_en) begin
          sym_chk(int'(hi_val));
          chk("scl_high_time", hi_cnt, 2 * Q);
        end
        if (byte_act) begin
          tb_bit++;
          tgt_drive();
          if (tb_bit == 3 && byte_cnt == stretch_at) stretch_left = 21;
        end
      end
      prev_scl = scl_l;
      prev_sda = sda_l;
      if (cmd_valid_in && cmd_ready_out && cmd_in[1]) begin
        if (tgt_q.size() > 0) cur = tgt_q.pop_front();
        else cur = '{1'b0, 8'hFF, 1'b1};
        byte_cnt++;
        byte_act = 1;
        tb_bit   = 0;
        tgt_drive();
      end
    end
  end

  // Stimulus.
  int base = 0;
  int n_bytes = 0;
  int model_data = 0;
  int model_ack = 0;

  task automatic issue(input logic [1:0] c, input logic [7:0] d, input logic a);
    bit ok;
    ok = 0;
    @(posedge clk); #1;
    cmd_valid_in = 1'b1; cmd_in = c; data_in = d; ack_in = a;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (cmd_ready_out) begin ok = 1; break; end
    end
    if (!ok) chk("accept_timeout", 0, 1);
    base = cyc;
    @(posedge clk); #1;
    cmd_valid_in = 1'b0;
  endtask

  task automatic at(input int n);
    while (cyc < base + n) @(negedge clk);
  endtask

  task automatic do_start();
    resp_q.push_back('{4 * Q + 1, model_data, model_ack});
    sym_q.push_back(2);
    issue(2'd0, 8'h00, 1'b0);
  endtask

  task automatic do_stop();
    resp_q.push_back('{4 * Q + 1, model_data, model_ack});
    sym_q.push_back(3);
    issue(2'd1, 8'h00, 1'b0);
  endtask

  task automatic do_write(input logic [7:0] d, input bit tack, input int lat);
    model_ack = int'(tack);
    resp_q.push_back('{lat, model_data, model_ack});
    for (int i = 7; i >= 0; i--) sym_q.push_back(int'(d[i]));
    sym_q.push_back(int'(tack));
    tgt_q.push_back('{1'b0, d, tack});
    n_bytes++;
    issue(2'd2, d, 1'b0);
  endtask

  task automatic do_read(input logic [7:0] d, input bit aack);
    model_data = int'(d);
    resp_q.push_back('{36 * Q + 1, model_data, model_ack});
    for (int i = 7; i >= 0; i--) sym_q.push_back(int'(d[i]));
    sym_q.push_back(int'(aack));
    tgt_q.push_back('{1'b1, d, 1'b0});
    n_bytes++;
    issue(2'd3, 8'h00, aack);
  endtask

  task automatic drain();
    for (int i = 0; i < 3000; i++) begin
      if (resp_q.size() == 0 && sym_q.size() == 0 && cmd_ready_out) break;
      @(negedge clk);
    end
    chk("drain_pending", resp_q.size() + sym_q.size(), 0);
  endtask

  initial begin
    int n0;
    cmd_valid_in = 1'b0; cmd_in = 2'd0; data_in = 8'h00; ack_in = 1'b0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("rst_scl", int'(scl_out), 1);
    chk("rst_sda", int'(sda_out), 1);
    chk("rst_ready", int'(cmd_ready_out), 1);
    chk("rst_busy", int'(busy_out), 0);
    chk("rst_done", int'(done_out), 0);
    chk("rst_data", int'(data_out), 0);
    chk("rst_ack", int'(ack_out), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    mon_en = 1;

    do_start();
    at(2);
    chk("start_busy", int'(busy_out), 1);
    chk("start_ready", int'(cmd_ready_out), 0);
    at(8);
    chk("start_sda_c8", int'(sda_out), 1);
    at(9);
    chk("start_sda_c9", int'(sda_out), 0);
    chk("start_scl_c9", int'(scl_out), 1);
    at(12);
    chk("start_scl_c12", int'(scl_out), 1);
    at(13);
    chk("start_scl_c13", int'(scl_out), 0);

    do_write(8'hA5, 1'b0, 36 * Q + 1);
    do_write(8'h5A, 1'b1, 36 * Q + 1);
    do_start();
    do_read(8'h3C, 1'b1);
    at(134);
    chk("read_nack_drive", int'(sda_out), 1);
    do_read(8'hC3, 1'b0);
    at(134);
    chk("read_ack_drive", int'(sda_out), 0);
    stretch_at = n_bytes + 1;
    do_write(8'h96, 1'b1, 36 * Q + 1 + 20);
    do_stop();
    drain();

    #1 rst = 1'b1;
    #1;
    chk("rst2_data", int'(data_out), 0);
    chk("rst2_ack", int'(ack_out), 0);
    chk("rst2_ready", int'(cmd_ready_out), 1);
    model_data = 0;
    model_ack  = 0;
    @(posedge clk); #1 rst = 1'b0;

    mon_en = 0;
    n0 = n_acc;
    tgt_q.push_back('{1'b0, 8'h00, 1'b0});
    n_bytes++;
    issue(2'd2, 8'h00, 1'b0);
    at(5);
    #1 cmd_valid_in = 1'b1; cmd_in = 2'd1;
    repeat (3) @(negedge clk);
    #1 cmd_valid_in = 1'b0;
    at(66);
    chk("pre_rst_scl", int'(scl_out), 0);
    chk("pre_rst_sda", int'(sda_out), 0);
    chk("busy_accepts", n_acc - n0, 1);
    #1 rst = 1'b1;
    #1;
    chk("midrst_scl", int'(scl_out), 1);
    chk("midrst_sda", int'(sda_out), 1);
    chk("midrst_busy", int'(busy_out), 0);
    chk("midrst_ready", int'(cmd_ready_out), 1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    mon_en = 1;

    do_start();
    do_write(8'h81, 1'b0, 36 * Q + 1);
    do_stop();
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_err, n_chk);
    $fatal(1);
  end

endmodule
